// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-stage PC generator.
//   pc_state_e : boot/run state of the PC generator FSM
//   pc_sel_e   : source selected for the next PC
//   INSN_LEN_C / INSN_LEN_F : byte length of compressed / full instructions
package pc_gen_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_SEQ   = 3'd1,
    SEL_RAS   = 3'd2,
    SEL_REDIR = 3'd3,
    SEL_TRAP  = 3'd4
  } pc_sel_e;

  localparam int INSN_LEN_C = 2;
  localparam int INSN_LEN_F = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (built only with PC_GEN_RAS_EN).
// Ports:
//   i_clk, i_rst (async active-low)
//   i_push, i_pop, i_push_data : stack operations; pop+push together
//                                replaces the top entry
//   o_top, o_empty, o_full     : current top entry and occupancy flags
// A push on a full stack overwrites the oldest entry; the count saturates.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q;      // next free slot; top lives at ptr_q-1
  logic [PW:0]   cnt_q;
  logic [PW-1:0] top_idx;
  logic          do_pop;

  assign top_idx = ptr_q - PW'(1);
  assign o_top   = mem_q[top_idx];
  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_pop && i_push) begin
      mem_q[top_idx] <= i_push_data;
    end else if (i_push) begin
      mem_q[ptr_q] <= i_push_data;
      ptr_q        <= ptr_q + PW'(1);
      if (!o_full) cnt_q <= cnt_q + (PW+1)'(1);
    end else if (do_pop) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator for an RV32IC core.
// Optional macro: PC_GEN_RAS_EN enables return prediction through pc_ras.
// Ports:
//   i_clk, i_rst (async active-low)
//   i_fetch_ready, i_stall, i_is_compressed : fetch handshake and length
//   i_trap_valid/i_trap_pc, i_redirect_valid/i_redirect_pc : redirects
//   i_call, i_ret      : call/return hints for the instruction at o_pc
//   o_pc, o_pc_valid   : current fetch PC and its valid
//   o_misalign         : one-cycle pulse after a redirect/trap with bit0 set
//   o_state            : FSM state, debug visibility
// Handshake: o_pc is offered while o_pc_valid=1 and is consumed on a cycle
// where i_fetch_ready=1 and i_stall=0 (fire). Without fire o_pc holds,
// except that a trap or redirect replaces it regardless of ready/stall.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              BOOT_CYCLES = 2,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_ready,
  input  logic            i_stall,
  input  logic            i_is_compressed,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_call,
  input  logic            i_ret,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  output logic            o_misalign,
  output pc_state_e       o_state
);
  localparam int CNT_W = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);

  pc_state_e       state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  pc_sel_e         sel;
  logic            run, fire, flush;
  logic [XLEN-1:0] seq_pc;
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

  assign run    = (state_q == RUN);
  assign fire   = run & i_fetch_ready & ~i_stall;
  assign flush  = i_trap_valid | i_redirect_valid;
  assign seq_pc = pc_q + (i_is_compressed ? XLEN'(INSN_LEN_C) : XLEN'(INSN_LEN_F));

`ifdef PC_GEN_RAS_EN
  logic ras_push, ras_pop;
  // Flushes cancel stack updates so a squashed call/ret leaves no trace.
  assign ras_push = run & fire & i_call & ~flush;
  assign ras_pop  = run & fire & i_ret  & ~flush;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (XLEN)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (ras_push),
    .i_pop       (ras_pop),
    .i_push_data (seq_pc),
    .o_top       (ras_top),
    .o_empty     (ras_empty),
    .o_full      ()
  );
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = i_call ^ i_ret;
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
`endif

  // Next-PC source selection, trap first.
  always_comb begin
    sel = SEL_HOLD;
    if (run) begin
      if (i_trap_valid)                        sel = SEL_TRAP;
      else if (i_redirect_valid)               sel = SEL_REDIR;
      else if (fire && i_ret && !ras_empty)    sel = SEL_RAS;
      else if (fire)                           sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    unique case (sel)
      SEL_TRAP: begin
        pc_d       = {i_trap_pc[XLEN-1:1], 1'b0};
        misalign_d = i_trap_pc[0];
      end
      SEL_REDIR: begin
        pc_d       = {i_redirect_pc[XLEN-1:1], 1'b0};
        misalign_d = i_redirect_pc[0];
      end
      SEL_RAS:  pc_d = ras_top;
      SEL_SEQ:  pc_d = seq_pc;
      default:  pc_d = pc_q;
    endcase
  end

  // Boot FSM: count down, leave BOOT on the clock that sees zero.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      BOOT: begin
        if (boot_cnt_q == '0) state_d    = RUN;
        else                  boot_cnt_d = boot_cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= CNT_W'(BOOT_CYCLES);
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_valid = run;
  assign o_misalign = misalign_q;
  assign o_state    = state_q;

endmodule
